// File: rtl/rat_pkg.sv
// Shared types and defaults for the flag register block and its interrupt logic.
package rat_pkg;

   localparam int SYNC_STAGES_DEFAULT = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SERVICE = 2'd2
   } int_state_e;

endpackage

// File: rtl/intr_sync.sv
// Brings the asynchronous INTR line into the CLK domain and flags its rising edges.
module intr_sync
   import rat_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic INTR,
   output logic EDGE
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   dly;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync <= '0;
         dly  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], INTR};
         dly  <= sync[SYNC_STAGES-1];
      end
   end

   assign EDGE = sync[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/rat_flags.sv
// Processor flag registers (C, Z, I) with a shadow copy and the interrupt request FSM.
module rat_flags
   import rat_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic ALU_C,
   input  logic ALU_Z,
   input  logic FLG_C_LD,
   input  logic FLG_Z_LD,
   input  logic FLG_C_SET,
   input  logic FLG_C_CLR,
   input  logic I_SET,
   input  logic I_CLR,
   input  logic RETIE,
   input  logic INTR,
   input  logic INT_ACK,
   output logic C_FLAG,
   output logic Z_FLAG,
   output logic I_FLAG,
   output logic INT_REQ
);

   int_state_e state, state_next;
   logic       pend, pend_next;
   logic       shadow_c, shadow_z;
   logic       edge_det;
   logic       int_accept;

   intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_intr_sync (
      .CLK  (CLK),
      .RST  (RST),
      .INTR (INTR),
      .EDGE (edge_det)
   );

   assign int_accept = (state == ST_PENDING) && INT_ACK;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      pend_next  = pend | edge_det;
      unique case (state)
         ST_IDLE: begin
            if ((pend || edge_det) && I_FLAG) begin
               state_next = ST_PENDING;
               pend_next  = 1'b0;
            end
         end
         ST_PENDING: begin
            if (INT_ACK) begin
               state_next = ST_SERVICE;
            end else if (I_CLR) begin
               // Request withdrawn by CLI is parked, not dropped.
               state_next = ST_IDLE;
               pend_next  = 1'b1;
            end
         end
         ST_SERVICE: begin
            if (RETIE) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         pend     <= 1'b0;
         shadow_c <= 1'b0;
         shadow_z <= 1'b0;
         C_FLAG   <= 1'b0;
         Z_FLAG   <= 1'b0;
         I_FLAG   <= 1'b0;
         INT_REQ  <= 1'b0;
      end else begin
         state   <= state_next;
         pend    <= pend_next;
         INT_REQ <= (state_next == ST_PENDING);

         if (int_accept) begin
            shadow_c <= C_FLAG;
            shadow_z <= Z_FLAG;
         end

         if (RETIE)          C_FLAG <= shadow_c;
         else if (FLG_C_CLR) C_FLAG <= 1'b0;
         else if (FLG_C_SET) C_FLAG <= 1'b1;
         else if (FLG_C_LD)  C_FLAG <= ALU_C;

         if (RETIE)         Z_FLAG <= shadow_z;
         else if (FLG_Z_LD) Z_FLAG <= ALU_Z;

         if (int_accept)  I_FLAG <= 1'b0;
         else if (RETIE)  I_FLAG <= 1'b1;
         else if (I_CLR)  I_FLAG <= 1'b0;
         else if (I_SET)  I_FLAG <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rat_flags.sv
// Scoreboard bench for rat_flags: a reference model queues the expected outputs for each edge.
module tb_rat_flags;
   import rat_pkg::*;

   localparam int S = SYNC_STAGES_DEFAULT;

   logic clk = 1'b0;
   logic rst, alu_c, alu_z, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr;
   logic i_set, i_clr, retie, intr, int_ack;
   logic c_flag, z_flag, i_flag, int_req;

   rat_flags #(.SYNC_STAGES(S)) dut (
      .CLK       (clk),
      .RST       (rst),
      .ALU_C     (alu_c),
      .ALU_Z     (alu_z),
      .FLG_C_LD  (flg_c_ld),
      .FLG_Z_LD  (flg_z_ld),
      .FLG_C_SET (flg_c_set),
      .FLG_C_CLR (flg_c_clr),
      .I_SET     (i_set),
      .I_CLR     (i_clr),
      .RETIE     (retie),
      .INTR      (intr),
      .INT_ACK   (int_ack),
      .C_FLAG    (c_flag),
      .Z_FLAG    (z_flag),
      .I_FLAG    (i_flag),
      .INT_REQ   (int_req)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic c;
      logic z;
      logic i;
      logic req;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: interrupt phase 0=idle 1=waiting for ack 2=in service
   logic m_c, m_z, m_i, m_sc, m_sz, m_pend;
   int   m_phase;
   logic hist[$];   // INTR values sampled at past edges, most recent first

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_c = 0; m_z = 0; m_i = 0; m_sc = 0; m_sz = 0; m_pend = 0; m_phase = 0;
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back(1'b0);
   endtask

   task automatic model_step();
      logic rise, ack, nc, nz, ni, npend;
      exp_t e;
      if (rst) begin
         model_reset();
      end else begin
         rise = hist[S-1] && !hist[S];
         ack  = (m_phase == 1) && int_ack;
         nc = retie ? m_sc : flg_c_clr ? 1'b0 : flg_c_set ? 1'b1 : flg_c_ld ? alu_c : m_c;
         nz = retie ? m_sz : flg_z_ld ? alu_z : m_z;
         ni = ack ? 1'b0 : retie ? 1'b1 : i_clr ? 1'b0 : i_set ? 1'b1 : m_i;
         if (ack) begin
            m_sc = m_c;
            m_sz = m_z;
         end
         npend = m_pend || rise;
         if (m_phase == 0) begin
            if ((m_pend || rise) && m_i) begin
               m_phase = 1;
               npend   = 0;
            end
         end else if (m_phase == 1) begin
            if (int_ack) m_phase = 2;
            else if (i_clr) begin
               m_phase = 0;
               npend   = 1;
            end
         end else if (retie) begin
            m_phase = 0;
         end
         m_c = nc; m_z = nz; m_i = ni; m_pend = npend;
         hist.push_front(intr);
         void'(hist.pop_back());
      end
      e.c = m_c; e.z = m_z; e.i = m_i; e.req = (m_phase == 1);
      exp_q.push_back(e);
   endtask

   // Applies current inputs for one edge, then drops the single-cycle controls.
   task automatic step();
      model_step();
      @(posedge clk);
      #2;
      rst = 0; flg_c_ld = 0; flg_z_ld = 0; flg_c_set = 0; flg_c_clr = 0;
      i_set = 0; i_clr = 0; retie = 0; int_ack = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic pulse_intr();
      intr = 1; step();
      intr = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("c_flag",  c_flag,  e.c);
            check("z_flag",  z_flag,  e.z);
            check("i_flag",  i_flag,  e.i);
            check("int_req", int_req, e.req);
         end
      end
   end

   initial begin : stimulus
      rst = 1; alu_c = 0; alu_z = 0; flg_c_ld = 0; flg_z_ld = 0; flg_c_set = 0;
      flg_c_clr = 0; i_set = 0; i_clr = 0; retie = 0; intr = 0; int_ack = 0;
      model_reset();
      step();
      rst = 1; step();

      // SEC and CLC together: clear wins; then a load from the ALU
      flg_c_set = 1; flg_c_clr = 1; step();
      flg_c_ld = 1; alu_c = 1; step();
      alu_c = 0;

      // Full interrupt round trip with flag save/restore
      i_set = 1; step();
      pulse_intr();
      idle(3);
      int_ack = 1; step();
      flg_z_ld = 1; alu_z = 1; step();
      alu_z = 0;
      retie = 1; step();
      idle(2);

      // Edge while disabled is held until interrupts are enabled
      i_clr = 1; step();
      pulse_intr();
      idle(4);
      i_set = 1; step();
      idle(2);
      int_ack = 1; step();
      retie = 1; step();
      idle(2);

      // CLI in PENDING withdraws then re-raises; ACK beats CLI
      pulse_intr();
      idle(3);
      i_clr = 1; step();
      idle(2);
      i_set = 1; step();
      idle(2);
      int_ack = 1; i_clr = 1; step();
      idle(1);

      // Two edges in SERVICE collapse into one request
      pulse_intr();
      idle(3);
      pulse_intr();
      idle(3);
      retie = 1; step();
      idle(3);
      int_ack = 1; step();
      idle(4);

      // Reset during service abandons it; no RETIE needed afterwards
      rst = 1; step();
      idle(1);
      i_set = 1; step();
      pulse_intr();
      idle(4);
      int_ack = 1; step();
      retie = 1; step();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         alu_c     = 1'($urandom_range(0, 1));
         alu_z     = 1'($urandom_range(0, 1));
         flg_c_ld  = ($urandom_range(0, 5) == 0);
         flg_z_ld  = ($urandom_range(0, 5) == 0);
         flg_c_set = ($urandom_range(0, 7) == 0);
         flg_c_clr = ($urandom_range(0, 7) == 0);
         i_set     = ($urandom_range(0, 4) == 0);
         i_clr     = ($urandom_range(0, 9) == 0);
         retie     = ($urandom_range(0, 9) == 0);
         int_ack   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) intr = ~intr;
         step();
      end

      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
